mips_mem_arbiter: RTL



---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_mem_arbiter_if.sv | 62 ++++++
 rtl/mips_prio_sel.sv | 33 +++
 rtl/mips_mem_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the pipe_MIPS32 unified-memory arbiter.
package mips_pkg;

    localparam int unsigned DW_DEFAULT = 32;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'd0;
    localparam gnt_t GNT_LD   = 2'd1;
    localparam gnt_t GNT_D    = 2'd2;
    localparam gnt_t GNT_F    = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Request/response bundle between the arbiter, its three requesters and the memory array.
interface mips_mem_arbiter_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) ();

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_ack;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic          f_req;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_rdata;
    logic          f_ack;

    logic          halt_in;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [1:0]    grant_id;
    logic          busy;

    modport slave (
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_ack,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack,
        input  f_req, f_addr,
        output f_rdata, f_ack,
        input  halt_in,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output grant_id, busy
    );

    modport master (
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_ack,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack,
        output f_req, f_addr,
        input  f_rdata, f_ack,
        output halt_in,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  grant_id, busy
    );

endinterface

// File: rtl/mips_prio_sel.sv
// Combinational priority picker: loader > data > fetch, with fetch promoted over data on force.
module mips_prio_sel
    import mips_pkg::*;
(
    input  logic ld_req_i,
    input  logic d_req_i,
    input  logic f_req_i,
    input  gnt_t mask_i,
    input  logic force_f_i,
    output gnt_t win_o
);

    logic ld_v, d_v, f_v;

    // The masked id is the requester still holding req while its ack is in flight.
    assign ld_v = ld_req_i && (mask_i != GNT_LD);
    assign d_v  = d_req_i  && (mask_i != GNT_D);
    assign f_v  = f_req_i  && (mask_i != GNT_F);

    always_comb begin
        win_o = GNT_NONE;
        if (ld_v) begin
            win_o = GNT_LD;
        end else if (f_v && force_f_i) begin
            win_o = GNT_F;
        end else if (d_v) begin
            win_o = GNT_D;
        end else if (f_v) begin
            win_o = GNT_F;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates the single-port unified memory between loader, MEM-stage data and IF-stage fetch.
module mips_mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned AW           = 10,
    parameter int unsigned DW           = DW_DEFAULT,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk1,
    input logic               rst,
    mips_mem_arbiter_if.slave bus
);

    localparam int unsigned   CW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] StarveMax = CW'(STARVE_LIMIT);

    state_e        state_q, state_d;
    gnt_t          win_q, win_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          ld_ack_q, ld_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          f_ack_q, f_ack_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [DW-1:0] f_rdata_q, f_rdata_d;

    gnt_t          sel;
    gnt_t          mask_id;
    logic [AW-1:0] sel_addr;
    logic          sel_we;
    logic [DW-1:0] sel_wdata;
    logic          f_req_m;
    logic          arb_en;
    logic          grant;
    logic          issue;

    assign f_req_m = bus.f_req & ~bus.halt_in;
    assign arb_en  = (state_q == StIdle) || (state_q == StResp);
    assign mask_id = (state_q == StResp) ? win_q : GNT_NONE;
    assign grant   = arb_en && (sel != GNT_NONE);
    assign issue   = (state_q == StIssue);

    mips_prio_sel u_prio_sel (
        .ld_req_i  (bus.ld_req),
        .d_req_i   (bus.d_req),
        .f_req_i   (f_req_m),
        .mask_i    (mask_id),
        .force_f_i (starve_q == StarveMax),
        .win_o     (sel)
    );

    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        unique case (sel)
            GNT_LD: begin
                sel_addr  = bus.ld_addr;
                sel_we    = bus.ld_we;
                sel_wdata = bus.ld_wdata;
            end
            GNT_D: begin
                sel_addr  = bus.d_addr;
                sel_we    = bus.d_we;
                sel_wdata = bus.d_wdata;
            end
            GNT_F: begin
                sel_addr  = bus.f_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        starve_d  = starve_q;
        ld_ack_d  = 1'b0;
        d_ack_d   = 1'b0;
        f_ack_d   = 1'b0;
        d_rdata_d = d_rdata_q;
        f_rdata_d = f_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StResp;
            end
            StResp: begin
                // mem_rdata is valid this cycle; capture it on the edge that raises ack.
                unique case (win_q)
                    GNT_LD: ld_ack_d = 1'b1;
                    GNT_D: begin
                        d_ack_d = 1'b1;
                        if (!we_q) d_rdata_d = bus.mem_rdata;
                    end
                    GNT_F: begin
                        f_ack_d = 1'b1;
                        if (!we_q) f_rdata_d = bus.mem_rdata;
                    end
                    default: ;
                endcase
                state_d = grant ? StIssue : StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (grant) begin
            win_d   = sel;
            addr_d  = sel_addr;
            we_d    = sel_we;
            wdata_d = sel_wdata;
        end

        if (!f_req_m) begin
            starve_d = '0;
        end else if (grant && (sel == GNT_F)) begin
            starve_d = '0;
        end else if (grant && (sel == GNT_D) && (starve_q != StarveMax)) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q   <= StIdle;
            win_q     <= GNT_NONE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            starve_q  <= '0;
            ld_ack_q  <= 1'b0;
            d_ack_q   <= 1'b0;
            f_ack_q   <= 1'b0;
            d_rdata_q <= '0;
            f_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            starve_q  <= starve_d;
            ld_ack_q  <= ld_ack_d;
            d_ack_q   <= d_ack_d;
            f_ack_q   <= f_ack_d;
            d_rdata_q <= d_rdata_d;
            f_rdata_q <= f_rdata_d;
        end
    end

    // The strobe is gated by rst so a write caught mid-reset never reaches the array.
    assign bus.mem_en    = issue && !rst;
    assign bus.mem_we    = issue && !rst && we_q;
    assign bus.mem_addr  = issue ? addr_q : '0;
    assign bus.mem_wdata = issue ? wdata_q : '0;

    assign bus.ld_ack   = ld_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.f_ack    = f_ack_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.f_rdata  = f_rdata_q;
    assign bus.grant_id = (state_q == StIdle) ? GNT_NONE : win_q;
    assign bus.busy     = (state_q != StIdle);

endmodule
